// File: rtl/ram_delay_mc_if.sv
// rtl/ram_delay_mc_if.sv - write/result bundle for the multi-channel RAM delay line.
interface ram_delay_mc_if #(
  parameter int P_NBITS_DATA = 42,
  parameter int P_NBITS_ADDR = 9,
  parameter int P_NBITS_CH   = 2,
  parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
);
  logic                    init;
  logic [P_NBITS_ADDR-1:0] n;
  logic                    wr;
  logic [P_NBITS_CH-1:0]   ch;
  logic [P_NBITS_DATA-1:0] d;
  logic                    stb_o;
  logic [P_NBITS_CH-1:0]   ch_o;
  logic [P_NBITS_DATA-1:0] qn;
  logic [P_NBITS_DATA-1:0] qo;
  logic                    valid;
  logic [P_NBITS_SUM-1:0]  sum;

  modport master (
    output init, n, wr, ch, d,
    input  stb_o, ch_o, qn, qo, valid, sum
  );

  modport slave (
    input  init, n, wr, ch, d,
    output stb_o, ch_o, qn, qo, valid, sum
  );
endinterface

// File: rtl/ram_delay_mc.sv
// rtl/ram_delay_mc.sv - P_NCH time-multiplexed delay lines sharing one block RAM,
// with per-channel fill tracking and boxcar sum over the last n samples.
module ram_delay_mc #(
  parameter int P_NBITS_DATA = 42,
  parameter int P_NBITS_ADDR = 9,
  parameter int P_NBITS_CH   = 2,
  parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
) (
  input logic          clk,
  input logic          rst_n,
  ram_delay_mc_if.slave bus
);
  localparam int P_NCH   = 2 ** P_NBITS_CH;
  localparam int P_DEPTH = 2 ** (P_NBITS_CH + P_NBITS_ADDR);

  logic [P_NBITS_DATA-1:0] mem [P_DEPTH];
  logic [P_NBITS_DATA-1:0] ram_q;

  logic [P_NBITS_ADDR-1:0] n_q;
  logic [P_NBITS_ADDR-1:0] wptr  [P_NCH];
  logic [P_NBITS_ADDR-1:0] fill  [P_NCH];
  logic [P_NBITS_SUM-1:0]  sum_r [P_NCH];

  logic                    p1_vld, p1_v0, p1_byp;
  logic [P_NBITS_CH-1:0]   p1_ch;
  logic [P_NBITS_DATA-1:0] p1_d;
  logic                    p2_vld, p2_v0, p2_byp;
  logic [P_NBITS_CH-1:0]   p2_ch;
  logic [P_NBITS_DATA-1:0] p2_d, p2_q;

  logic                    wr_acc;
  logic [P_NBITS_ADDR-1:0] rptr;
  logic                    v0;
  logic [P_NBITS_DATA-1:0] qo_sel;
  logic [P_NBITS_DATA-1:0] sub;
  logic [P_NBITS_SUM-1:0]  nsum;

  always_comb begin
    wr_acc = bus.wr & ~bus.init;
    rptr   = wptr[bus.ch] - n_q;
    v0     = (fill[bus.ch] >= n_q);
    // n_q=0 reads the word being written; take the sample itself instead.
    qo_sel = p2_byp ? p2_d : p2_q;
    sub    = p2_v0 ? qo_sel : '0;
    nsum   = sum_r[p2_ch] + {{(P_NBITS_SUM-P_NBITS_DATA){1'b0}}, p2_d}
                          - {{(P_NBITS_SUM-P_NBITS_DATA){1'b0}}, sub};
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{bus.ch, wptr[bus.ch]}] <= bus.d;
    end
    ram_q <= mem[{bus.ch, rptr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      for (int i = 0; i < P_NCH; i++) begin
        wptr[i]  <= '0;
        fill[i]  <= '0;
        sum_r[i] <= '0;
      end
      p1_vld    <= 1'b0;
      p1_v0     <= 1'b0;
      p1_byp    <= 1'b0;
      p1_ch     <= '0;
      p1_d      <= '0;
      p2_vld    <= 1'b0;
      p2_v0     <= 1'b0;
      p2_byp    <= 1'b0;
      p2_ch     <= '0;
      p2_d      <= '0;
      p2_q      <= '0;
      bus.stb_o <= 1'b0;
      bus.ch_o  <= '0;
      bus.qn    <= '0;
      bus.qo    <= '0;
      bus.valid <= 1'b0;
      bus.sum   <= '0;
    end else if (bus.init) begin
      n_q <= bus.n;
      for (int i = 0; i < P_NCH; i++) begin
        wptr[i]  <= '0;
        fill[i]  <= '0;
        sum_r[i] <= '0;
      end
      p1_vld    <= 1'b0;
      p2_vld    <= 1'b0;
      bus.stb_o <= 1'b0;
    end else begin
      p1_vld <= bus.wr;
      p1_ch  <= bus.ch;
      p1_d   <= bus.d;
      p1_v0  <= v0;
      p1_byp <= (n_q == '0);
      if (bus.wr) begin
        wptr[bus.ch] <= wptr[bus.ch] + 1'b1;
        if (fill[bus.ch] < n_q) begin
          fill[bus.ch] <= fill[bus.ch] + 1'b1;
        end
      end

      p2_vld <= p1_vld;
      p2_ch  <= p1_ch;
      p2_d   <= p1_d;
      p2_v0  <= p1_v0;
      p2_byp <= p1_byp;
      p2_q   <= ram_q;

      bus.stb_o <= p2_vld;
      if (p2_vld) begin
        bus.ch_o     <= p2_ch;
        bus.qn       <= p2_d;
        bus.qo       <= qo_sel;
        bus.valid    <= p2_v0;
        bus.sum      <= nsum;
        sum_r[p2_ch] <= nsum;
      end
    end
  end
endmodule

// File: tb/tb_ram_delay_mc.sv
// tb/tb_ram_delay_mc.sv - randomized and directed bench for ram_delay_mc against
// a history-array reference model.
module tb_ram_delay_mc;
  localparam int DW = 42;
  localparam int AW = 9;
  localparam int CW = 2;
  localparam int SW = DW + AW;
  localparam int NCH = 4;
  localparam int HD = 4096;

  logic clk;
  logic rst_n;

  ram_delay_mc_if #(.P_NBITS_DATA(DW), .P_NBITS_ADDR(AW), .P_NBITS_CH(CW)) bus ();

  ram_delay_mc #(.P_NBITS_DATA(DW), .P_NBITS_ADDR(AW), .P_NBITS_CH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // reference model: every sample since the last init, per channel
  logic [DW-1:0] hist [NCH][HD];
  int            cnt  [NCH];
  int            nm;

  // expected outputs, ring indexed by the negedge at which they become visible
  logic          e_stb   [8];
  logic [CW-1:0] e_ch    [8];
  logic [DW-1:0] e_qn    [8];
  logic [DW-1:0] e_qo    [8];
  logic          e_valid [8];
  logic [SW-1:0] e_sum   [8];
  logic [DW-1:0] last_qn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
  endtask

  task automatic model_write(input logic [CW-1:0] c, input logic [DW-1:0] dd, input int slot);
    int k;
    int lo;
    logic [63:0] acc;
    k = cnt[c];
    hist[c][k] = dd;
    e_stb[slot]   = 1'b1;
    e_ch[slot]    = c;
    e_qn[slot]    = dd;
    e_valid[slot] = (k >= nm);
    if (nm == 0) begin
      e_qo[slot]  = dd;
      e_sum[slot] = '0;
    end else begin
      e_qo[slot] = (k >= nm) ? hist[c][k-nm] : '0;
      lo = (k - nm + 1 > 0) ? k - nm + 1 : 0;
      acc = '0;
      for (int j = lo; j <= k; j++) acc += 64'(hist[c][j]);
      e_sum[slot] = acc[SW-1:0];
    end
    cnt[c] = k + 1;
  endtask

  // called at a negedge: check what is due now, then drive the next cycle
  task automatic step(input logic w, input logic [CW-1:0] c, input logic [DW-1:0] dd,
                      input logic ini, input logic [AW-1:0] nn);
    int s;
    s = cyc % 8;
    check("stb_o", 64'(bus.stb_o), 64'(e_stb[s]));
    if (e_stb[s]) begin
      check("ch_o", 64'(bus.ch_o), 64'(e_ch[s]));
      check("qn", 64'(bus.qn), 64'(e_qn[s]));
      check("valid", 64'(bus.valid), 64'(e_valid[s]));
      if (e_valid[s]) begin
        check("qo", 64'(bus.qo), 64'(e_qo[s]));
        check("sum", 64'(bus.sum), 64'(e_sum[s]));
      end
      last_qn = e_qn[s];
    end else begin
      check("hold_qn", 64'(bus.qn), 64'(last_qn));
    end
    e_stb[s] = 1'b0;

    bus.wr   = w;
    bus.ch   = c;
    bus.d    = dd;
    bus.init = ini;
    bus.n    = nn;
    if (ini) begin
      nm = int'(nn);
      clear_model();
      for (int k = 1; k <= 3; k++) e_stb[(cyc + k) % 8] = 1'b0;
    end else if (w) begin
      model_write(c, dd, (cyc + 3) % 8);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic pulse_reset();
    bus.wr   = 1'b0;
    bus.init = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_stb", 64'(bus.stb_o), 64'd0);
    check("rst_ch", 64'(bus.ch_o), 64'd0);
    check("rst_qn", 64'(bus.qn), 64'd0);
    check("rst_qo", 64'(bus.qo), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    rst_n = 1'b1;
    nm = 0;
    clear_model();
    for (int i = 0; i < 8; i++) e_stb[i] = 1'b0;
    last_qn = '0;
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  initial begin
    logic [AW-1:0] rn;
    rst_n    = 1'b0;
    bus.wr   = 1'b0;
    bus.init = 1'b0;
    bus.n    = '0;
    bus.ch   = '0;
    bus.d    = '0;
    nm       = 0;
    last_qn  = '0;
    clear_model();
    for (int i = 0; i < 8; i++) e_stb[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_stb", 64'(bus.stb_o), 64'd0);
    check("reset_sum", 64'(bus.sum), 64'd0);
    check("reset_qo", 64'(bus.qo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // n=4, ch0 ramp
    step(1'b0, 2'd0, '0, 1'b1, 9'd4);
    for (int k = 1; k <= 10; k++) step(1'b1, 2'd0, DW'(k), 1'b0, '0);
    idle(4);

    // n=2, two interleaved channels
    step(1'b0, 2'd0, '0, 1'b1, 9'd2);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'd0, DW'(100 + k), 1'b0, '0);
      step(1'b1, 2'd1, DW'(200 + k), 1'b0, '0);
    end
    idle(4);

    // maximum delay with pointer wrap
    step(1'b0, 2'd0, '0, 1'b1, 9'd511);
    for (int i = 0; i < 1100; i++) step(1'b1, 2'd3, DW'(i), 1'b0, '0);
    idle(4);

    // bypass
    step(1'b0, 2'd0, '0, 1'b1, 9'd0);
    step(1'b1, 2'd1, DW'(7), 1'b0, '0);
    step(1'b1, 2'd1, DW'(8), 1'b0, '0);
    idle(4);

    // init colliding with a write mid-stream
    step(1'b0, 2'd0, '0, 1'b1, 9'd4);
    for (int k = 0; k < 6; k++) step(1'b1, 2'd2, rnd_d(), 1'b0, '0);
    step(1'b1, 2'd2, rnd_d(), 1'b1, 9'd4);
    for (int k = 0; k < 5; k++) step(1'b1, 2'd2, rnd_d(), 1'b0, '0);
    idle(4);

    // randomized interleaving, full-scale data
    for (int r = 0; r < 4; r++) begin
      case (r)
        0: rn = 9'd1;
        1: rn = 9'd3;
        2: rn = 9'd17;
        default: rn = 9'($urandom_range(1, 40));
      endcase
      step(1'b0, 2'd0, '0, 1'b1, rn);
      for (int i = 0; i < 400; i++)
        step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rnd_d(), 1'b0, '0);
      idle(4);
    end

    // asynchronous reset mid-burst
    step(1'b0, 2'd0, '0, 1'b1, 9'd3);
    for (int k = 0; k < 5; k++) step(1'b1, 2'd0, rnd_d(), 1'b0, '0);
    pulse_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, rnd_d(), 1'b0, '0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_delay_mc.md
Name: ram_delay_mc

Overview:
- Multi-channel successor to the single-channel RAM delay line.
- Time-multiplexes P_NCH independent delay lines in one block RAM. Each write is tagged with a channel, and each channel keeps its own write pointer and fill count.
- For every accepted write the block returns the newest sample (qn), the sample delayed by n writes on the same channel (qo), a valid flag, and a per-channel running window sum (boxcar) over the last n samples.
- Sits in the digitiser data path ahead of baseline-subtraction and trigger logic.

Parameters:
P_NBITS_DATA, 42, sample width
P_NBITS_ADDR, 9, per-channel depth is 2^P_NBITS_ADDR words; max delay is 2^P_NBITS_ADDR-1
P_NBITS_CH, 2, channel index width; P_NCH = 2^P_NBITS_CH channels
P_NBITS_SUM, P_NBITS_DATA+P_NBITS_ADDR, running sum width (cannot overflow for unsigned data)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
init  in  1  synchronous clear of all channels; latches n
n  in  P_NBITS_ADDR  delay in writes, sampled only when init=1
wr  in  1  write strobe, one sample per cycle max
ch  in  P_NBITS_CH  channel of this write
d  in  P_NBITS_DATA  write data
stb_o  out  1  one-cycle pulse per accepted write, 2 clocks after wr sampled
ch_o  out  P_NBITS_CH  channel of output
qn  out  P_NBITS_DATA  the written sample d
qo  out  P_NBITS_DATA  sample written n writes earlier on ch_o
valid  out  1  qo and sum are meaningful
sum  out  P_NBITS_SUM  sum of the last n samples on ch_o, current one included

Behaviour:
- Reset (rst_n=0, async):
  - stb_o, valid, ch_o, qn, qo, sum all 0.
  - Per-channel wptr, fill and sum registers cleared; n_q=0; pipeline flushed.
  - RAM contents are not cleared; they are don't-care because valid is gated by fill.
- init=1:
  - n_q<=n; all wptr, fill and sum registers cleared; in-flight pipeline stages killed (no stb_o for them).
  - init and wr in the same cycle: init wins, the write is dropped.
- Accepted write (wr=1, init=0), stage 0:
  - RAM[{ch,wptr[ch]}]<=d.
  - Read address {ch, (wptr[ch]-n_q) mod 2^P_NBITS_ADDR}.
  - wptr[ch]<=wptr[ch]+1, wrapping at 2^P_NBITS_ADDR.
  - fill[ch] increments, saturating at n_q; tag v0=(fill[ch]>=n_q), using the pre-increment value.
- Stage 1: RAM read data registered. d, ch and v0 are carried alongside.
- Stage 2 (output register):
  - qo=RAM data.
  - sum[ch]<=sum[ch]+d-(v0?qo:0); the sum output is the updated value.
  - stb_o=1; valid=v0.
- n_q=0: bypass. qo=qn, valid=1 from the first write, sum stays 0. No RAM read-during-write hazard.
- n_q>=1: the read address never equals the write address in the same cycle. Back-to-back writes to the same channel are legal every cycle; stage-2 sum updates are sequential per channel.
- Outputs hold their last values while stb_o=0. Only stb_o pulses.
- Channels are fully independent; interleaving order is arbitrary.
- Throughput: 1 write/clk; latency fixed at 2 clks; no backpressure.

Test Plan:
- n=4 via init, ch0 writes d=1..10 back-to-back:
  - d=1..4 give valid=0; d=4 gives sum=10.
  - d=5 gives qo=1, valid=1, sum=14.
  - d=k (k>=5) gives qo=k-4, sum=4k-6.
  - stb_o exactly 2 clks after each wr.
- n=2, alternating ch0 d=100,101,102 and ch1 d=200,201,202:
  - ch0 third output qo=100, sum=203.
  - ch1 third output qo=200, sum=403.
  - No cross-channel leakage.
- n=511, 1100 writes ch3 d=i:
  - For i>=511: qo=i-511, valid=1, sum=511*i-130305.
  - wptr wraps without a glitch.
- n=0, writes d=7,8 on ch1: qo=qn each time, valid=1, sum=0.
- Mid-stream init with wr=1 in the same cycle (n=4):
  - The dropped write produces no stb_o, and in-flight outputs are suppressed.
  - The next 4 writes on that channel give valid=0; the 5th gives valid=1.
- rst_n low for 1 ns mid-burst: all outputs 0 immediately; no stb_o for pre-reset writes; n_q=0 afterward.
